// File: rtl/deser_10_outputs_pkg.sv
// Shared definitions for the 10-lane serial-to-parallel gatherer that feeds
// the FP32 adder tree: lane count, default widths, the +0.0 pad word and
// the slot index type.
package deser_10_outputs_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_TAG_W = 8;
  localparam int LANES     = 10;
  localparam int SLOT_W    = 4;

  // +0.0 is the neutral element of the downstream sum, so it is the pad word.
  localparam logic [31:0] FP_POS_ZERO = 32'h0000_0000;

  typedef logic [SLOT_W-1:0] slot_t;

  localparam slot_t LAST_SLOT = slot_t'(LANES - 1);

endpackage

// File: rtl/deser_slot_ctr.sv
// Slot counter for the gatherer. Slot 0 is the EMPTY state, slots 1..9 are
// FILLING. Decodes group completion (10th word, or an early close when
// DESER_10_OUTPUTS_FLUSH_EN is defined) and the mask of lanes to pad with +0.0.
module deser_slot_ctr
  import deser_10_outputs_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             accept,
  input  logic             last,
  output slot_t            slot,
  output logic             complete,
  output logic [LANES-1:0] pad_mask
);

  logic flush_hit;

`ifdef DESER_10_OUTPUTS_FLUSH_EN
  assign flush_hit = accept & last;
`else
  // Without flush support the close marker is kept on the port but ignored.
  logic unused_last;
  assign unused_last = last;
  assign flush_hit   = 1'b0;
`endif

  // A group closes on the word landing in slot 9, or early on a flush.
  assign complete = accept & ((slot == LAST_SLOT) | flush_hit);

  // Lanes above the closing slot are padded only on an early close.
  always_comb begin
    // NOTE: default first so every path assigns pad_mask and no latch is inferred.
    pad_mask = '0;
    for (int i = 0; i < LANES; i++) begin
      if (flush_hit && (slot_t'(i) > slot)) pad_mask[i] = 1'b1;
    end
  end

  // Advance one slot per accepted word, returning to EMPTY on completion.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with <= so every flop samples pre-edge values.
    if (rst)           slot <= '0;
    else if (accept)   slot <= complete ? '0 : slot_t'(slot + 1'b1);
  end

endmodule

// File: rtl/deser_10_outputs.sv
// Serial-to-parallel gatherer: packs ten accepted FP32 words into out0..out9
// and pulses valid_out for one cycle per group, tagged by group_id.
// Optional early group close: define DESER_10_OUTPUTS_FLUSH_EN.
module deser_10_outputs
  import deser_10_outputs_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int TAG_W = DEF_TAG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic [WIDTH-1:0] out4,
  output logic [WIDTH-1:0] out5,
  output logic [WIDTH-1:0] out6,
  output logic [WIDTH-1:0] out7,
  output logic [WIDTH-1:0] out8,
  output logic [WIDTH-1:0] out9,
  output logic             valid_out,
  output logic [TAG_W-1:0] group_id
);

  logic             accept;
  logic             complete;
  slot_t            slot;
  logic [LANES-1:0] pad_mask;
  logic [WIDTH-1:0] buf_q [LANES];
  logic [WIDTH-1:0] out_q [LANES];

  assign accept = in_valid & in_ready;

  deser_slot_ctr u_slot_ctr (
    .clk      (clk),
    .rst      (rst),
    .accept   (accept),
    .last     (in_last),
    .slot     (slot),
    .complete (complete),
    .pad_mask (pad_mask)
  );

  // Ready stays low through the first cycle after reset, then high for good:
  // the adder tree is fully pipelined and never stalls.
  always_ff @(posedge clk) begin
    if (rst) in_ready <= 1'b0;
    else     in_ready <= 1'b1;
  end

  // Collection buffer: holds words of the group in progress, apart from the
  // output lanes so the previous group stays visible while filling.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: buffer is cleared on reset so a discarded partial group leaves no trace.
      for (int i = 0; i < LANES; i++) buf_q[i] <= '0;
    end else if (accept && !complete) begin
      buf_q[slot] <= in_data;
    end
  end

  // Output lanes, group tag and valid pulse, all updated the cycle after completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LANES; i++) out_q[i] <= '0;
      valid_out <= 1'b0;
      group_id  <= '0;
    end else begin
      valid_out <= complete;
      if (complete) begin
        group_id <= group_id + TAG_W'(1);
        for (int i = 0; i < LANES; i++) begin
          if (pad_mask[i])              out_q[i] <= WIDTH'(FP_POS_ZERO);
          else if (slot_t'(i) == slot)  out_q[i] <= in_data;
          else                          out_q[i] <= buf_q[i];
        end
      end
    end
  end

  assign out0 = out_q[0];
  assign out1 = out_q[1];
  assign out2 = out_q[2];
  assign out3 = out_q[3];
  assign out4 = out_q[4];
  assign out5 = out_q[5];
  assign out6 = out_q[6];
  assign out7 = out_q[7];
  assign out8 = out_q[8];
  assign out9 = out_q[9];

endmodule

// File: tb/tb_deser_10_outputs.sv
// Directed bench for deser_10_outputs: reset, back-to-back and gapped groups,
// flush (both builds of DESER_10_OUTPUTS_FLUSH_EN), mid-group reset and
// group_id wrap.
module tb_deser_10_outputs;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic [31:0] in_data = 32'h0;
  logic        in_ready;
  logic        valid_out;
  logic [7:0]  group_id;
  logic [31:0] out0, out1, out2, out3, out4, out5, out6, out7, out8, out9;
  logic [31:0] outs [10];

  int tests_run = 0;
  int fails = 0;
  int pulse_cnt = 0;
  int consec_cnt = 0;
  logic prev_valid = 1'b0;

  logic [31:0] words [10];
  logic [31:0] fdat  [10];
  logic [31:0] exp_l [10];

  always #5 clk = ~clk;

  deser_10_outputs dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out0      (out0),
    .out1      (out1),
    .out2      (out2),
    .out3      (out3),
    .out4      (out4),
    .out5      (out5),
    .out6      (out6),
    .out7      (out7),
    .out8      (out8),
    .out9      (out9),
    .valid_out (valid_out),
    .group_id  (group_id)
  );

  assign outs[0] = out0;
  assign outs[1] = out1;
  assign outs[2] = out2;
  assign outs[3] = out3;
  assign outs[4] = out4;
  assign outs[5] = out5;
  assign outs[6] = out6;
  assign outs[7] = out7;
  assign outs[8] = out8;
  assign outs[9] = out9;

  // Pulse monitor on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (valid_out === 1'b1) begin
      pulse_cnt++;
      if (prev_valid) consec_cnt++;
    end
    prev_valid = (valid_out === 1'b1);
  end

  task automatic send(input logic [31:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b1; in_data = 32'hDEAD_BEEF;
    repeat (3) @(posedge clk);
    #1;
    tests_run++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_ready got=%b exp=0", in_ready); end
    tests_run++; if (valid_out !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b exp=0", valid_out); end
    tests_run++; if (group_id !== 8'd0) begin fails++; $display("FAIL reset_gid got=%0d exp=0", group_id); end
    for (int i = 0; i < 10; i++) begin
      tests_run++; if (outs[i] !== 32'h0) begin fails++; $display("FAIL reset_out%0d got=%h exp=0", i, outs[i]); end
    end
    rst = 1'b0;
    tests_run++; if (in_ready !== 1'b0) begin fails++; $display("FAIL post_reset_ready0 got=%b exp=0", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    tests_run++; if (in_ready !== 1'b1) begin fails++; $display("FAIL post_reset_ready1 got=%b exp=1", in_ready); end
    tests_run++; if (valid_out !== 1'b0) begin fails++; $display("FAIL post_reset_valid got=%b exp=0", valid_out); end
  endtask

  task automatic test_back_to_back;
    int p0;
    p0 = pulse_cnt;
    for (int k = 0; k < 10; k++) begin
      send(words[k], 1'b0);
      if (k < 9) begin
        tests_run++; if (valid_out !== 1'b0) begin fails++; $display("FAIL b2b_early word=%0d got=%b exp=0", k, valid_out); end
      end
    end
    tests_run++; if (valid_out !== 1'b1) begin fails++; $display("FAIL b2b_pulse got=%b exp=1", valid_out); end
    tests_run++; if (group_id !== 8'd1) begin fails++; $display("FAIL b2b_gid got=%0d exp=1", group_id); end
    for (int i = 0; i < 10; i++) begin
      tests_run++; if (outs[i] !== words[i]) begin fails++; $display("FAIL b2b_out%0d got=%h exp=%h", i, outs[i], words[i]); end
    end
    idle(1);
    tests_run++; if (valid_out !== 1'b0) begin fails++; $display("FAIL b2b_pulse_width got=%b exp=0", valid_out); end
    tests_run++; if (out9 !== words[9]) begin fails++; $display("FAIL b2b_hold got=%h exp=%h", out9, words[9]); end
    tests_run++; if (pulse_cnt - p0 !== 1) begin fails++; $display("FAIL b2b_pulses got=%0d exp=1", pulse_cnt - p0); end
  endtask

  task automatic test_gapped;
    for (int k = 0; k < 10; k++) begin
      send(words[k], 1'b0);
      if (k < 9) begin
        tests_run++; if (valid_out !== 1'b0) begin fails++; $display("FAIL gap_early word=%0d got=%b exp=0", k, valid_out); end
        idle(1);
        tests_run++; if (valid_out !== 1'b0) begin fails++; $display("FAIL gap_idle word=%0d got=%b exp=0", k, valid_out); end
      end
    end
    tests_run++; if (valid_out !== 1'b1) begin fails++; $display("FAIL gap_pulse got=%b exp=1", valid_out); end
    tests_run++; if (group_id !== 8'd2) begin fails++; $display("FAIL gap_gid got=%0d exp=2", group_id); end
    for (int i = 0; i < 10; i++) begin
      tests_run++; if (outs[i] !== words[i]) begin fails++; $display("FAIL gap_out%0d got=%h exp=%h", i, outs[i], words[i]); end
    end
    idle(1);
    tests_run++; if (valid_out !== 1'b0) begin fails++; $display("FAIL gap_pulse_width got=%b exp=0", valid_out); end
  endtask

  task automatic test_flush;
    for (int k = 0; k < 4; k++) begin
      send(fdat[k], k == 3);
      if (k < 3) begin
        tests_run++; if (out5 !== words[5]) begin fails++; $display("FAIL flush_hold got=%h exp=%h", out5, words[5]); end
      end
    end
`ifdef DESER_10_OUTPUTS_FLUSH_EN
    for (int i = 0; i < 10; i++) exp_l[i] = (i < 4) ? fdat[i] : 32'h0;
`else
    tests_run++; if (valid_out !== 1'b0) begin fails++; $display("FAIL flush_ignored got=%b exp=0", valid_out); end
    for (int k = 4; k < 10; k++) begin
      send(fdat[k], 1'b0);
      if (k < 9) begin
        tests_run++; if (valid_out !== 1'b0) begin fails++; $display("FAIL flush_early word=%0d got=%b exp=0", k, valid_out); end
      end
    end
    for (int i = 0; i < 10; i++) exp_l[i] = fdat[i];
`endif
    tests_run++; if (valid_out !== 1'b1) begin fails++; $display("FAIL flush_pulse got=%b exp=1", valid_out); end
    tests_run++; if (group_id !== 8'd3) begin fails++; $display("FAIL flush_gid got=%0d exp=3", group_id); end
    for (int i = 0; i < 10; i++) begin
      tests_run++; if (outs[i] !== exp_l[i]) begin fails++; $display("FAIL flush_out%0d got=%h exp=%h", i, outs[i], exp_l[i]); end
    end
    idle(1);
  endtask

  task automatic test_mid_reset;
    int p0;
    p0 = pulse_cnt;
    for (int k = 0; k < 5; k++) send(32'h5555_0000 | 32'(k), 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tests_run++; if (valid_out !== 1'b0) begin fails++; $display("FAIL mrst_valid got=%b exp=0", valid_out); end
    tests_run++; if (group_id !== 8'd0) begin fails++; $display("FAIL mrst_gid got=%0d exp=0", group_id); end
    tests_run++; if (in_ready !== 1'b0) begin fails++; $display("FAIL mrst_ready got=%b exp=0", in_ready); end
    for (int i = 0; i < 10; i++) begin
      tests_run++; if (outs[i] !== 32'h0) begin fails++; $display("FAIL mrst_out%0d got=%h exp=0", i, outs[i]); end
    end
    idle(1);
    for (int k = 0; k < 10; k++) send(words[9-k], 1'b0);
    tests_run++; if (valid_out !== 1'b1) begin fails++; $display("FAIL mrst_pulse got=%b exp=1", valid_out); end
    tests_run++; if (group_id !== 8'd1) begin fails++; $display("FAIL mrst_new_gid got=%0d exp=1", group_id); end
    for (int i = 0; i < 10; i++) begin
      tests_run++; if (outs[i] !== words[9-i]) begin fails++; $display("FAIL mrst_new_out%0d got=%h exp=%h", i, outs[i], words[9-i]); end
    end
    idle(1);
    tests_run++; if (pulse_cnt - p0 !== 1) begin fails++; $display("FAIL mrst_pulses got=%0d exp=1", pulse_cnt - p0); end
  endtask

  task automatic test_gid_wrap;
    int p0;
    logic [31:0] v;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1);
    p0 = pulse_cnt;
    for (int g = 0; g < 256; g++) begin
      for (int k = 0; k < 10; k++) begin
        v = {8'(g), 8'(k), 16'hA5A5};
        send(v, 1'b0);
        if (k == 5 && g > 0) begin
          tests_run++;
          if (out0 !== {8'(g - 1), 8'd0, 16'hA5A5}) begin
            fails++; $display("FAIL wrap_hold grp=%0d got=%h exp=%h", g, out0, {8'(g - 1), 8'd0, 16'hA5A5});
          end
        end
      end
      tests_run++; if (valid_out !== 1'b1) begin fails++; $display("FAIL wrap_pulse grp=%0d got=%b exp=1", g, valid_out); end
      tests_run++; if (group_id !== 8'(g + 1)) begin fails++; $display("FAIL wrap_gid grp=%0d got=%0d exp=%0d", g, group_id, 8'(g + 1)); end
      tests_run++; if (out9 !== v) begin fails++; $display("FAIL wrap_out9 grp=%0d got=%h exp=%h", g, out9, v); end
    end
    tests_run++; if (group_id !== 8'd0) begin fails++; $display("FAIL wrap_final_gid got=%0d exp=0", group_id); end
    idle(1);
    tests_run++; if (pulse_cnt - p0 !== 256) begin fails++; $display("FAIL wrap_pulses got=%0d exp=256", pulse_cnt - p0); end
  endtask

  initial begin
    words[0] = 32'h3F80_0000; words[1] = 32'h4000_0000;
    words[2] = 32'h4040_0000; words[3] = 32'h4080_0000;
    words[4] = 32'h40A0_0000; words[5] = 32'h40C0_0000;
    words[6] = 32'h40E0_0000; words[7] = 32'h4100_0000;
    words[8] = 32'h4110_0000; words[9] = 32'h4120_0000;
    for (int i = 0; i < 10; i++) fdat[i] = 32'hC100_0000 | 32'(i + 1);

    test_reset;
    test_back_to_back;
    test_gapped;
    test_flush;
    test_mid_reset;
    test_gid_wrap;

    tests_run++; if (consec_cnt !== 0) begin fails++; $display("FAIL consecutive_pulses got=%0d exp=0", consec_cnt); end

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
